mips_multicycle_processor: RTL and testbench

Multi-cycle MIPS core, the successor to the single-cycle processor top level. It executes the same instruction subset plus load/store through one shared external memory port with a ready handshake, so fetch and data accesses take a variable number of cycles. It also decodes memory-mapped I/O addresses internally, driving `PortOut` from stores and returning `PortIn` to loads. It sits at the top of the processor hierarchy; the bench or SoC supplies program/data memory.

---
 rtl/mips_multicycle_processor.sv | 181 ++++++++++++++++++
 tb/tb_mips_multicycle_processor.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_processor.sv
// rtl/mips_multicycle_processor.sv - multi-cycle MIPS core with one shared memory port and MMIO
module mips_multicycle_processor #(
    parameter logic [31:0] RESET_PC    = 32'h0040_0000,
    parameter logic [31:0] IO_IN_ADDR  = 32'h1001_0024,
    parameter logic [31:0] IO_OUT_ADDR = 32'h1001_0028
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  PortIn,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] PortOut,
    output logic [31:0] ALUResultOut,
    output logic        illegal_op
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0] alu_q, alu_d, mdr_q, mdr_d, port_q, port_d;
    logic        ill_q, ill_d;
    logic [31:0] regs_q [32];

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] simm, zimm, jtarget;
    logic        is_lw, is_sw, io_hit;

    assign op      = ir_q[31:26];
    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign shamt   = ir_q[10:6];
    assign funct   = ir_q[5:0];
    assign simm    = {{16{ir_q[15]}}, ir_q[15:0]};
    assign zimm    = {16'h0000, ir_q[15:0]};
    assign jtarget = {pc_q[31:28], ir_q[25:0], 2'b00};
    assign is_lw   = (op == 6'h23);
    assign is_sw   = (op == 6'h2B);
    // alu_q holds the effective address while in MEM
    assign io_hit  = (is_lw && alu_q == IO_IN_ADDR) || (is_sw && alu_q == IO_OUT_ADDR);

    assign mem_req      = !reset && (state_q == S_FETCH || (state_q == S_MEM && !io_hit));
    assign mem_we       = (state_q == S_MEM) && is_sw;
    assign mem_addr     = (state_q == S_MEM) ? {alu_q[31:2], 2'b00} : pc_q;
    assign mem_wdata    = b_q;
    assign PortOut      = port_q;
    assign ALUResultOut = alu_q;
    assign illegal_op   = ill_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        port_d   = port_q;
        ill_d    = ill_q;
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'h0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = regs_q[rs];
                b_d     = regs_q[rt];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    6'h00: begin
                        state_d = S_WB;
                        case (funct)
                            6'h20: alu_d = a_q + b_q;
                            6'h22: alu_d = a_q - b_q;
                            6'h24: alu_d = a_q & b_q;
                            6'h25: alu_d = a_q | b_q;
                            6'h27: alu_d = ~(a_q | b_q);
                            6'h00: alu_d = b_q << shamt;
                            6'h02: alu_d = b_q >> shamt;
                            6'h08: begin
                                pc_d    = a_q;
                                state_d = S_FETCH;
                            end
                            default: begin
                                ill_d   = 1'b1;
                                state_d = S_FETCH;
                            end
                        endcase
                    end
                    6'h08: begin alu_d = a_q + simm;            state_d = S_WB; end
                    6'h0D: begin alu_d = a_q | zimm;            state_d = S_WB; end
                    6'h0F: begin alu_d = {ir_q[15:0], 16'h0000}; state_d = S_WB; end
                    6'h04: if (a_q == b_q) pc_d = pc_q + (simm << 2);
                    6'h05: if (a_q != b_q) pc_d = pc_q + (simm << 2);
                    6'h02: pc_d = jtarget;
                    6'h03: begin
                        pc_d     = jtarget;
                        rf_we    = 1'b1;
                        rf_waddr = 5'd31;
                        rf_wdata = pc_q;
                    end
                    6'h23, 6'h2B: begin
                        alu_d   = a_q + simm;
                        state_d = S_MEM;
                    end
                    default: ill_d = 1'b1;
                endcase
            end
            S_MEM: begin
                if (io_hit) begin
                    if (is_lw) begin
                        mdr_d   = {24'h000000, PortIn};
                        state_d = S_WB;
                    end else begin
                        port_d  = b_q;
                        state_d = S_FETCH;
                    end
                end else if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = is_lw ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = (is_lw || op != 6'h00) ? rt : rd;
                rf_wdata = is_lw ? mdr_q : alu_q;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            port_q  <= '0;
            ill_q   <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            port_q  <= port_d;
            ill_q   <= ill_d;
            // $0 is never written, so it always reads back as zero
            if (rf_we && rf_waddr != 5'd0) regs_q[rf_waddr] <= rf_wdata;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_processor.sv
// tb/tb_mips_multicycle_processor.sv - directed plus random program checked against an ISA-level model
module tb_mips_multicycle_processor;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] IO_IN    = 32'h1001_0024;
    localparam logic [31:0] IO_OUT   = 32'h1001_0028;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  PortIn;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, PortOut, ALUResultOut;
    logic        illegal_op;

    mips_multicycle_processor dut (
        .clk(clk), .reset(reset), .PortIn(PortIn), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .PortOut(PortOut),
        .ALUResultOut(ALUResultOut), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fetch;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] alu;
        logic [31:0] pout;
        logic        ill;
        int          start;
        int          cumw;
    } xact_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem  [logic [31:0]];
    logic [31:0] mmem [logic [31:0]];
    logic [31:0] mr [32];
    logic [31:0] m_alu, m_pout;
    logic        m_ill;
    int          m_cyc;
    xact_t       exp_q[$];
    xact_t       log_q[$];

    int    cyc, cumw, wl, maxw, wp;
    bit    pend, hold;
    xact_t cur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    // memory responder: random wait states, stability checks, transaction log
    always @(negedge clk) begin
        if (reset) begin
            pend = 0; mem_ready = 1'b0; cumw = 0;
        end else if (mem_req) begin
            if (!pend) begin
                pend = 1;
                cur.fetch = 1'b0; cur.addr = mem_addr; cur.we = mem_we; cur.wdata = mem_wdata;
                cur.alu = ALUResultOut; cur.pout = PortOut; cur.ill = illegal_op;
                cur.start = cyc; cur.cumw = cumw;
                wl = (hold && mem_addr == 32'h40) ? 1000000 : int'($urandom_range(maxw, 0));
            end else begin
                chk($sformatf("stable_addr@%0d", cyc), mem_addr, cur.addr);
                chk($sformatf("stable_we@%0d", cyc), {31'h0, mem_we}, {31'h0, cur.we});
                chk($sformatf("stable_wdata@%0d", cyc), mem_wdata, cur.wdata);
            end
            if (wl > 0) begin
                wl--; cumw++;
                mem_ready = 1'b0; mem_rdata = $urandom;
            end else begin
                mem_ready = 1'b1;
                mem_rdata = mem.exists(cur.addr) ? mem[cur.addr] : 32'h0;
                if (cur.we) mem[cur.addr] = cur.wdata;
                log_q.push_back(cur);
                pend = 0;
            end
        end else begin
            pend = 0;
            mem_ready = 1'($urandom_range(1, 0));
            mem_rdata = $urandom;
        end
    end

    function automatic logic [31:0] r_op(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, f};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic emit(input logic [31:0] w);
        mem[RESET_PC + 32'(wp * 4)]  = w;
        mmem[RESET_PC + 32'(wp * 4)] = w;
        wp++;
    endtask

    task automatic push_exp(input logic f, input logic [31:0] a, input logic we, input logic [31:0] wd);
        xact_t e;
        e.fetch = f; e.addr = a; e.we = we; e.wdata = wd;
        e.alu = m_alu; e.pout = m_pout; e.ill = m_ill; e.start = m_cyc; e.cumw = 0;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [4:0] d, input logic [31:0] v);
        if (d != 5'd0) mr[d] = v;
    endtask

    task automatic alu_wr(input logic [4:0] d, input logic [31:0] v);
        m_alu = v; wr(d, v); m_cyc += 4;
    endtask

    // ISA-level interpreter: one loop iteration per instruction, cycle cost by instruction class
    task automatic model_run(input logic [31:0] end_pc);
        logic [31:0] pc, ir, a, b, simm, ad;
        pc = RESET_PC;
        for (int n = 0; n < 5000; n++) begin
            push_exp(1'b1, pc, 1'b0, 32'h0);
            if (pc == end_pc) break;
            ir = mmem.exists(pc) ? mmem[pc] : 32'h0;
            pc = pc + 32'd4;
            a = mr[ir[25:21]]; b = mr[ir[20:16]];
            simm = {{16{ir[15]}}, ir[15:0]};
            case (ir[31:26])
                6'h00: case (ir[5:0])
                    6'h20: alu_wr(ir[15:11], a + b);
                    6'h22: alu_wr(ir[15:11], a - b);
                    6'h24: alu_wr(ir[15:11], a & b);
                    6'h25: alu_wr(ir[15:11], a | b);
                    6'h27: alu_wr(ir[15:11], ~(a | b));
                    6'h00: alu_wr(ir[15:11], b << ir[10:6]);
                    6'h02: alu_wr(ir[15:11], b >> ir[10:6]);
                    6'h08: begin pc = a; m_cyc += 3; end
                    default: begin m_ill = 1'b1; m_cyc += 3; end
                endcase
                6'h08: alu_wr(ir[20:16], a + simm);
                6'h0D: alu_wr(ir[20:16], a | {16'h0, ir[15:0]});
                6'h0F: alu_wr(ir[20:16], {ir[15:0], 16'h0});
                6'h04: begin if (a == b) pc = pc + simm * 4; m_cyc += 3; end
                6'h05: begin if (a != b) pc = pc + simm * 4; m_cyc += 3; end
                6'h02: begin pc = {pc[31:28], ir[25:0], 2'b00}; m_cyc += 3; end
                6'h03: begin wr(5'd31, pc); pc = {pc[31:28], ir[25:0], 2'b00}; m_cyc += 3; end
                6'h23: begin
                    ad = a + simm; m_alu = ad; m_cyc += 5;
                    if (ad == IO_IN) wr(ir[20:16], {24'h0, PortIn});
                    else begin
                        push_exp(1'b0, {ad[31:2], 2'b00}, 1'b0, 32'h0);
                        wr(ir[20:16], mmem.exists({ad[31:2], 2'b00}) ? mmem[{ad[31:2], 2'b00}] : 32'h0);
                    end
                end
                6'h2B: begin
                    ad = a + simm; m_alu = ad; m_cyc += 4;
                    if (ad == IO_OUT) m_pout = b;
                    else begin
                        push_exp(1'b0, {ad[31:2], 2'b00}, 1'b1, b);
                        mmem[{ad[31:2], 2'b00}] = b;
                    end
                end
                default: begin m_ill = 1'b1; m_cyc += 3; end
            endcase
        end
    endtask

    initial begin
        logic [31:0] end_pc;
        logic [4:0]  rd, rs, rt;
        logic [15:0] imm, off;
        reset = 1'b1; PortIn = 8'hA5; mem_ready = 1'b0; mem_rdata = 32'h0;
        maxw = 2; hold = 0; wp = 0; pend = 0; wl = 0; cumw = 0;
        m_alu = 0; m_pout = 0; m_ill = 0; m_cyc = 0;
        for (int i = 0; i < 32; i++) mr[i] = 32'h0;

        emit({6'h02, 26'h010_0008});           // j main (0x00400020)
        emit(32'h0); emit(32'h0); emit(32'h0);
        emit(i_op(6'h08, 5'd0, 5'd16, 16'd7));  // subroutine at 0x00400010
        emit(r_op(6'h08, 5'd31, 5'd0, 5'd0, 5'd0));
        emit(32'h0); emit(32'h0);
        emit(i_op(6'h08, 5'd0, 5'd8, 16'd5));
        emit(i_op(6'h08, 5'd0, 5'd9, 16'hFFFD));
        emit(r_op(6'h20, 5'd8, 5'd9, 5'd10, 5'd0));
        emit(r_op(6'h27, 5'd10, 5'd0, 5'd11, 5'd0));
        emit(r_op(6'h00, 5'd0, 5'd8, 5'd12, 5'd4));
        emit(i_op(6'h0F, 5'd0, 5'd28, 16'h1000));
        emit(i_op(6'h0D, 5'd28, 5'd28, 16'h8000));
        emit(i_op(6'h2B, 5'd28, 5'd8, 16'h0));
        emit(i_op(6'h23, 5'd28, 5'd13, 16'h0));
        emit(i_op(6'h2B, 5'd28, 5'd13, 16'h4));
        emit(i_op(6'h0F, 5'd0, 5'd1, 16'h1001));
        emit(i_op(6'h23, 5'd1, 5'd14, 16'h24));
        emit(i_op(6'h2B, 5'd1, 5'd14, 16'h28));
        emit(i_op(6'h08, 5'd0, 5'd15, 16'd2));
        emit(i_op(6'h08, 5'd15, 5'd15, 16'hFFFF));
        emit(i_op(6'h05, 5'd15, 5'd0, 16'hFFFE)); // bne back one instruction
        emit({6'h03, 26'h010_0004});           // jal 0x00400010
        emit(i_op(6'h04, 5'd8, 5'd0, 16'd1));   // beq not taken
        emit(i_op(6'h08, 5'd0, 5'd17, 16'd1));
        emit(32'hFC00_0000);                    // opcode 0x3F
        emit(i_op(6'h08, 5'd0, 5'd18, 16'd9));
        for (int k = 0; k < 30; k++) begin
            rd = 5'($urandom_range(27, 2)); rs = 5'($urandom_range(27, 0)); rt = 5'($urandom_range(27, 0));
            imm = 16'($urandom); off = 16'($urandom_range(15, 0) * 4);
            case ($urandom_range(11, 0))
                0: emit(r_op(6'h20, rs, rt, rd, 5'd0));
                1: emit(r_op(6'h22, rs, rt, rd, 5'd0));
                2: emit(r_op(6'h24, rs, rt, rd, 5'd0));
                3: emit(r_op(6'h25, rs, rt, rd, 5'd0));
                4: emit(r_op(6'h27, rs, rt, rd, 5'd0));
                5: emit(r_op(6'h00, 5'd0, rt, rd, imm[4:0]));
                6: emit(r_op(6'h02, 5'd0, rt, rd, imm[4:0]));
                7: emit(i_op(6'h08, rs, rd, imm));
                8: emit(i_op(6'h0D, rs, rd, imm));
                9: emit(i_op(6'h0F, 5'd0, rd, imm));
                10: emit(i_op(6'h2B, 5'd28, rt, off));
                default: emit(i_op(6'h23, 5'd28, rd, off));
            endcase
        end
        emit(r_op(6'h01, 5'd8, 5'd9, 5'd10, 5'd0)); // undecoded funct
        for (int r = 1; r < 32; r++) emit(i_op(6'h2B, 5'd28, 5'(r), 16'(32'h100 + r * 4)));
        end_pc = RESET_PC + 32'(wp * 4);
        emit(i_op(6'h04, 5'd0, 5'd0, 16'hFFFF));

        model_run(end_pc);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_req", {31'h0, mem_req}, 32'h0);
        chk("reset_portout", PortOut, 32'h0);
        chk("reset_illegal", {31'h0, illegal_op}, 32'h0);
        chk("reset_alu", ALUResultOut, 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        for (int t = 0; t < 30000 && log_q.size() < exp_q.size(); t++) @(posedge clk);
        chk("trace_complete", {31'h0, log_q.size() >= exp_q.size()}, 32'h1);
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk($sformatf("x%0d_addr", i), log_q[i].addr, exp_q[i].addr);
            chk($sformatf("x%0d_we", i), {31'h0, log_q[i].we}, {31'h0, exp_q[i].we});
            if (exp_q[i].we) chk($sformatf("x%0d_wdata", i), log_q[i].wdata, exp_q[i].wdata);
            if (exp_q[i].fetch) begin
                chk($sformatf("x%0d_alu", i), log_q[i].alu, exp_q[i].alu);
                chk($sformatf("x%0d_portout", i), log_q[i].pout, exp_q[i].pout);
                chk($sformatf("x%0d_illegal", i), {31'h0, log_q[i].ill}, {31'h0, exp_q[i].ill});
                chk($sformatf("x%0d_cycle", i), 32'(log_q[i].start - log_q[i].cumw), 32'(exp_q[i].start));
            end
        end

        // reset while a load is stuck waiting for memory
        @(negedge clk); reset = 1'b1; hold = 1;
        mem[RESET_PC]      = i_op(6'h23, 5'd0, 5'd5, 16'h0040);
        mem[32'h40]        = 32'hDEAD_BEEF;
        mem[RESET_PC + 4]  = i_op(6'h04, 5'd0, 5'd0, 16'hFFFF);
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        log_q.delete();
        for (int t = 0; t < 100 && !(mem_req && mem_addr == 32'h40); t++) @(negedge clk);
        chk("lw_wait_seen", {31'h0, mem_req && mem_addr == 32'h40}, 32'h1);
        repeat (3) @(negedge clk);
        chk("lw_still_waiting", {31'h0, mem_req}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_mem_req", {31'h0, mem_req}, 32'h0);
        mem[RESET_PC]     = i_op(6'h2B, 5'd0, 5'd5, 16'h0080);
        mem[RESET_PC + 4] = i_op(6'h04, 5'd0, 5'd0, 16'hFFFF);
        hold = 0;
        @(posedge clk); #1 reset = 1'b0;
        log_q.delete();
        for (int t = 0; t < 200 && log_q.size() < 2; t++) @(posedge clk);
        chk("abort_trace", {31'h0, log_q.size() >= 2}, 32'h1);
        if (log_q.size() >= 2) begin
            chk("restart_fetch", log_q[0].addr, RESET_PC);
            chk("abort_sw_addr", log_q[1].addr, 32'h80);
            chk("abort_sw_we", {31'h0, log_q[1].we}, 32'h1);
            chk("abort_no_regwrite", log_q[1].wdata, 32'h0);
        end
        chk("abort_portout", PortOut, 32'h0);
        chk("abort_illegal", {31'h0, illegal_op}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
